// File: rtl/nes_joypad_port.sv
// Console-side $4016/$4017 controller port: strobe latch, two 8-bit serial shifters, per-pad A/B turbo.
// Latency: rd_data is registered, valid the cycle after a read edge. No backpressure: every read edge is served immediately.
module nes_joypad_port #(
  parameter logic [6:0]  OPEN_BUS_HI = 7'h20,
  parameter logic [23:0] TURBO_DIV   = 24'd833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_4016,
  input  logic       wr_data,
  input  logic       rd_4016,
  input  logic       rd_4017,
  input  logic [7:0] pad1,
  input  logic [7:0] pad2,
  input  logic [1:0] turbo_en,
  output logic [7:0] rd_data,
  output logic       strobe
);

  logic        strobe_q, strobe_d;
  logic [7:0]  sr1_q, sr1_d;
  logic [7:0]  sr2_q, sr2_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [23:0] turbo_cnt_q, turbo_cnt_d;
  logic        turbo_phase_q, turbo_phase_d;
  logic        rd1_prev_q, rd1_prev_d;
  logic        rd2_prev_q, rd2_prev_d;

  logic [7:0]  ep1, ep2;
  logic        rd1_edge, rd2_edge;
  logic        rd1_bit, rd2_bit;

  // Turbo phase 0 masks A/B to released; phase 1 passes them through.
  always_comb begin
    turbo_cnt_d   = turbo_cnt_q + 24'd1;
    turbo_phase_d = turbo_phase_q;
    if (turbo_cnt_q == TURBO_DIV - 24'd1) begin
      turbo_cnt_d   = 24'd0;
      turbo_phase_d = ~turbo_phase_q;
    end
  end

  always_comb begin
    ep1 = pad1;
    ep2 = pad2;
    if (turbo_en[0] && !turbo_phase_q) ep1[1:0] = 2'b00;
    if (turbo_en[1] && !turbo_phase_q) ep2[1:0] = 2'b00;
  end

  assign rd1_edge = rd_4016 && !rd1_prev_q;
  assign rd2_edge = rd_4017 && !rd2_prev_q;

  // While strobe is high the register is being reloaded, so the live A bit is what a read sees.
  assign rd1_bit = strobe_q ? ep1[0] : sr1_q[0];
  assign rd2_bit = strobe_q ? ep2[0] : sr2_q[0];

  always_comb begin
    strobe_d   = wr_4016 ? wr_data : strobe_q;
    rd1_prev_d = rd_4016;
    rd2_prev_d = rd_4017;
    sr1_d      = sr1_q;
    sr2_d      = sr2_q;
    rd_data_d  = rd_data_q;

    // Reload/shift follows the strobe value before any same-cycle write.
    if (strobe_q) begin
      sr1_d = ep1;
      sr2_d = ep2;
    end else begin
      if (rd1_edge) sr1_d = {1'b1, sr1_q[7:1]};
      if (rd2_edge) sr2_d = {1'b1, sr2_q[7:1]};
    end

    if (rd1_edge)      rd_data_d = {OPEN_BUS_HI, rd1_bit};
    else if (rd2_edge) rd_data_d = {OPEN_BUS_HI, rd2_bit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q      <= 1'b0;
      sr1_q         <= 8'h00;
      sr2_q         <= 8'h00;
      rd_data_q     <= 8'h00;
      turbo_cnt_q   <= 24'd0;
      turbo_phase_q <= 1'b0;
      rd1_prev_q    <= 1'b0;
      rd2_prev_q    <= 1'b0;
    end else begin
      strobe_q      <= strobe_d;
      sr1_q         <= sr1_d;
      sr2_q         <= sr2_d;
      rd_data_q     <= rd_data_d;
      turbo_cnt_q   <= turbo_cnt_d;
      turbo_phase_q <= turbo_phase_d;
      rd1_prev_q    <= rd1_prev_d;
      rd2_prev_q    <= rd2_prev_d;
    end
  end

  assign rd_data = rd_data_q;
  assign strobe  = strobe_q;

endmodule
